// File: rtl/ob_mem_drain.sv
// ob_mem_drain: reads result rows from the output-buffer SRAM after a run
// and serializes each row into DRIVER_WIDTH-bit chunks on a valid/ready
// stream, element 0 least-significant bits first.
module ob_mem_drain #(
  parameter int WIDTH        = 8,
  parameter int COL          = 4,
  parameter int O_SIZE       = 256,
  parameter int DRIVER_WIDTH = 8,
  localparam int RW          = COL * WIDTH,
  localparam int AW          = $clog2(O_SIZE)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [AW-1:0]           base_addr_i,
  input  logic [AW:0]             num_rows_i,
  output logic                    mem_cenb_o,
  output logic                    mem_wenb_o,
  output logic [AW-1:0]           mem_addr_o,
  input  logic [RW-1:0]           mem_data_i,
  output logic [DRIVER_WIDTH-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int NCH = RW / DRIVER_WIDTH;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW:0]   rows_left;
  logic [RW-1:0] shift_reg;
  logic [RW-1:0] shift_next;
  logic [CW-1:0] chunk_cnt;

  // The memory port is only ever read.
  assign mem_wenb_o = 1'b1;

  // Row contents once the chunk currently on data_o has been consumed.
  always_comb begin
    shift_next = shift_reg >> DRIVER_WIDTH;
  end

  // Drain sequencer; all outputs are registered alongside the state so they
  // line up with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr       <= '0;
      rows_left  <= '0;
      shift_reg  <= '0;
      chunk_cnt  <= '0;
      mem_cenb_o <= 1'b1;
      mem_addr_o <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            busy_o <= 1'b1;
            if (num_rows_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state      <= READ;
              addr       <= base_addr_i;
              rows_left  <= num_rows_i;
              mem_cenb_o <= 1'b0;
              mem_addr_o <= base_addr_i;
            end
          end
        end
        READ: begin
          state      <= CAPT;
          mem_cenb_o <= 1'b1;
        end
        CAPT: begin
          state     <= SEND;
          shift_reg <= mem_data_i;
          chunk_cnt <= '0;
          addr      <= (addr == AW'(O_SIZE - 1)) ? '0 : addr + AW'(1);
          rows_left <= rows_left - (AW + 1)'(1);
          data_o    <= mem_data_i[DRIVER_WIDTH-1:0];
          valid_o   <= 1'b1;
        end
        SEND: begin
          if (ready_i) begin
            shift_reg <= shift_next;
            chunk_cnt <= chunk_cnt + CW'(1);
            data_o    <= shift_next[DRIVER_WIDTH-1:0];
            if (chunk_cnt == CW'(NCH - 1)) begin
              valid_o <= 1'b0;
              if (rows_left != '0) begin
                // addr already advanced in CAPT, so it names the next row.
                state      <= READ;
                mem_cenb_o <= 1'b0;
                mem_addr_o <= addr;
              end else begin
                state  <= DONE;
                done_o <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mem_cenb_o <= 1'b1;
          valid_o    <= 1'b0;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ob_mem_drain.sv
// Self-checking bench for ob_mem_drain: table of drains checked against a
// queue-based reference model, plus reset-abort and start-while-busy cases.
module tb_ob_mem_drain;

  localparam int WIDTH  = 8;
  localparam int COL    = 4;
  localparam int O_SIZE = 256;
  localparam int DW     = 8;
  localparam int RW     = COL * WIDTH;
  localparam int AW     = $clog2(O_SIZE);
  localparam int NCH    = RW / DW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   num_rows_i;
  logic          mem_cenb_o;
  logic          mem_wenb_o;
  logic [AW-1:0] mem_addr_o;
  logic [RW-1:0] mem_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;
  logic          done_o;

  ob_mem_drain #(
    .WIDTH(WIDTH),
    .COL(COL),
    .O_SIZE(O_SIZE),
    .DRIVER_WIDTH(DW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .num_rows_i(num_rows_i),
    .mem_cenb_o(mem_cenb_o),
    .mem_wenb_o(mem_wenb_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Sync-read SRAM with one cycle of latency.
  logic [RW-1:0] mem [O_SIZE];
  always @(posedge clk) if (!mem_cenb_o) mem_data_i <= mem[mem_addr_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_addr[$];
  int  acc_cnt, chunk_seen, done_cnt, first_valid_cyc;
  int  ready_mode = 0;
  bit  prev_stall = 0;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: the drain is the list of rows base..base+num-1 modulo
  // the depth, each split into chunks lowest bits first.
  task automatic build_expect(input int base, input int num);
    logic [RW-1:0] row;
    int a;
    exp_data.delete();
    exp_addr.delete();
    for (int r = 0; r < num; r++) begin
      a = (base + r) % O_SIZE;
      exp_addr.push_back(AW'(a));
      row = mem[a];
      for (int c = 0; c < NCH; c++) exp_data.push_back(row[c*DW +: DW]);
    end
    acc_cnt = 0;
    chunk_seen = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
  endtask

  // Consumer ready: 0 always high, 1 repeating 1,0,0,1, otherwise random.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream/memory monitor sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (prev_stall) begin
          check("stall_valid", valid_o, 1);
          check("stall_data", data_o, prev_data);
        end
        if (!mem_cenb_o) begin
          acc_cnt++;
          check("mem_wenb", mem_wenb_o, 1);
          if (exp_addr.size() != 0) check("mem_addr", mem_addr_o, exp_addr.pop_front());
          else check("extra_access", 1, 0);
        end
        if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (valid_o && ready_i) begin
          chunk_seen++;
          if (exp_data.size() != 0) check("chunk_data", data_o, exp_data.pop_front());
          else check("extra_chunk", 1, 0);
        end
        if (done_o) begin
          done_cnt++;
          check("done_busy", busy_o, 1);
        end
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic drain(input int base, input int num, input int mode,
                       input int exp_acc, input int exp_chunks, input bit spam);
    int t0;
    bit seen;
    ready_mode = mode;
    build_expect(base, num);
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    num_rows_i  = (AW + 1)'(num);
    @(posedge clk);
    #1;
    t0          = cyc;
    start_i     = 1'b0;
    base_addr_i = AW'(base + 77);
    num_rows_i  = (AW + 1)'(3);
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (spam) start_i = i[0];
      if (done_o) begin
        seen = 1;
        if (num == 0) check("zero_done_lat", cyc - t0, 0);
      end
    end
    check("done_seen", seen, 1);
    if (spam) begin
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    check("access_count", acc_cnt, exp_acc);
    check("chunk_count", chunk_seen, exp_chunks);
    check("done_count", done_cnt, 1);
    check("leftover_chunks", exp_data.size(), 0);
    if (num > 0) check("first_valid_lat", first_valid_cyc - t0, 2);
    else check("zero_no_valid", first_valid_cyc, 32'hffff_ffff);
  endtask

  typedef struct {
    int base;
    int num;
    int mode;
    int exp_acc;
    int exp_chunks;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int b, n;
    bit seen;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    num_rows_i  = '0;
    for (int i = 0; i < O_SIZE; i++) mem[i] = $urandom;
    mem[5] = 32'h4433_2211;
    mem[6] = 32'h8877_6655;

    b = $urandom_range(0, O_SIZE - 1);
    n = $urandom_range(1, 12);
    tbl[0] = '{5, 2, 0, 2, 8};
    tbl[1] = '{5, 1, 1, 1, 4};
    tbl[2] = '{255, 3, 0, 3, 12};
    tbl[3] = '{9, 0, 0, 0, 0};
    tbl[4] = '{17, 256, 0, 256, 1024};
    tbl[5] = '{b, n, 2, n, n * NCH};
    b = $urandom_range(200, O_SIZE - 1);
    n = $urandom_range(40, 80);
    tbl[6] = '{b, n, 2, n, n * NCH};

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_cenb", mem_cenb_o, 1);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);

    foreach (tbl[i]) drain(tbl[i].base, tbl[i].num, tbl[i].mode,
                           tbl[i].exp_acc, tbl[i].exp_chunks, 1'b0);

    // start_i pulsed throughout the drain and in the done_o cycle.
    drain(5, 2, 0, 2, 8, 1'b1);
    repeat (5) @(negedge clk);
    check("spam_stays_idle", busy_o, 0);
    check("spam_no_access", acc_cnt, 2);

    // Reset asserted mid-SEND aborts without a done_o pulse.
    ready_mode = 1;
    build_expect(5, 2);
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    base_addr_i = AW'(5);
    num_rows_i  = (AW + 1)'(2);
    @(posedge clk);
    #1 start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    check("abort_reached_send", seen, 1);
    @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    check("abort_cenb", mem_cenb_o, 1);
    check("abort_addr", mem_addr_o, 0);
    check("abort_data", data_o, 0);
    check("abort_valid", valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_still_idle", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
